// File: rtl/fg_trapezoid_gen.sv
// fg_trapezoid_gen: trapezoid/pulse generator with its own period
// counter and a double-buffered config applied at period boundaries.
// Ports: clk_i/rst_i sync active-high reset; clk_en_i tick enable;
//   enable_i/mode_i/trig_i run control; cfg_valid_i/cfg_ready_o
//   shadow handshake; period_i..invert_i config; out_o signed sample;
//   state_o/busy_o/period_start_o status.
module fg_trapezoid_gen #(
  parameter int CNT_W  = 32,
  parameter int WAVE_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clk_en_i,
  input  logic              enable_i,
  input  logic              mode_i,
  input  logic              trig_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CNT_W-1:0]  period_i,
  input  logic [CNT_W-1:0]  on_time_i,
  input  logic [WAVE_W-1:0] k_rise_i,
  input  logic [WAVE_W-1:0] k_fall_i,
  input  logic [WAVE_W-1:0] amplitude_i,
  input  logic [WAVE_W:0]   offset_i,
  input  logic              invert_i,
  output logic [WAVE_W:0]   out_o,
  output logic [2:0]        state_o,
  output logic              busy_o,
  output logic              period_start_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RISE = 3'd1,
    S_HOLD = 3'd2,
    S_FALL = 3'd3,
    S_LOW  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAVE_W-1:0] val_q, val_d;
  logic [WAVE_W:0]   out_q, out_d;

  logic              s_full;
  logic [CNT_W-1:0]  s_period, s_on;
  logic [WAVE_W-1:0] s_krise, s_kfall, s_amp;
  logic [WAVE_W:0]   s_off;
  logic              s_inv;

  logic [CNT_W-1:0]  a_period, a_on;
  logic [WAVE_W-1:0] a_krise, a_kfall, a_amp;
  logic [WAVE_W:0]   a_off;
  logic              a_inv;

  // Values that will be active after this tick's shadow copy.
  logic [CNT_W-1:0]  e_period, e_on;
  assign e_period = s_full ? s_period : a_period;
  assign e_on     = s_full ? s_on : a_on;

  logic idle, tick, can_start, restart_ok;
  logic per_end, on_end, start, load;

  assign idle       = (state_q == S_IDLE);
  assign tick       = clk_en_i;
  assign can_start  = enable_i && (e_period != '0)
                      && (!mode_i || trig_i);
  assign restart_ok = enable_i && !mode_i
                      && (e_period != '0);
  assign per_end    = !idle
                      && (cnt_q == a_period - CNT_W'(1));
  assign on_end     = (state_q == S_RISE || state_q == S_HOLD)
                      && (cnt_q == a_on - CNT_W'(1));
  assign start      = tick && !rst_i
                      && (idle ? can_start
                               : (per_end && restart_ok));
  assign load       = tick && s_full && (idle || start);

  // Shared slope adder: add k_rise in RISE, subtract k_fall in FALL.
  // In FALL the MSB flags a negative result (val < k_fall).
  logic              sub;
  logic [WAVE_W:0]   opb, sum;
  logic              rise_hit, fall_zero;

  assign sub       = (state_q == S_FALL);
  assign opb       = sub ? ~{1'b0, a_kfall} : {1'b0, a_krise};
  assign sum       = {1'b0, val_q} + opb
                     + {{WAVE_W{1'b0}}, sub};
  assign rise_hit  = (sum >= {1'b0, a_amp});
  assign fall_zero = sum[WAVE_W] || (sum == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_full   <= 1'b0;
      s_period <= '0;
      s_on     <= '0;
      s_krise  <= '0;
      s_kfall  <= '0;
      s_amp    <= '0;
      s_off    <= '0;
      s_inv    <= 1'b0;
    end else if (cfg_valid_i && !s_full) begin
      s_full   <= 1'b1;
      s_period <= period_i;
      s_on     <= on_time_i;
      s_krise  <= k_rise_i;
      s_kfall  <= k_fall_i;
      s_amp    <= amplitude_i;
      s_off    <= offset_i;
      s_inv    <= invert_i;
    end else if (load) begin
      s_full   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_period <= '0;
      a_on     <= '0;
      a_krise  <= '0;
      a_kfall  <= '0;
      a_amp    <= '0;
      a_off    <= '0;
      a_inv    <= 1'b0;
    end else if (load) begin
      a_period <= s_period;
      a_on     <= s_on;
      a_krise  <= s_krise;
      a_kfall  <= s_kfall;
      a_amp    <= s_amp;
      a_off    <= s_off;
      a_inv    <= s_inv;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      out_q   <= '0;
    end else if (tick) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    unique case (state_q)
      S_IDLE: begin
        if (can_start) begin
          cnt_d   = '0;
          val_d   = '0;
          state_d = (e_on == '0) ? S_LOW : S_RISE;
        end
      end
      S_RISE: begin
        val_d = rise_hit ? a_amp : sum[WAVE_W-1:0];
        if (rise_hit) state_d = S_HOLD;
      end
      S_HOLD: val_d = a_amp;
      S_FALL: begin
        val_d = fall_zero ? '0 : sum[WAVE_W-1:0];
        if (fall_zero) state_d = S_LOW;
      end
      S_LOW: val_d = '0;
      default: state_d = S_IDLE;
    endcase
    if (!idle) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (per_end) begin
        cnt_d = '0;
        val_d = '0;
        if (restart_ok)
          state_d = (e_on == '0) ? S_LOW : S_RISE;
        else
          state_d = S_IDLE;
      end else if (on_end) begin
        state_d = S_FALL;
      end
    end
  end

  // Output stage: optional negate, add offset one bit wider,
  // then clamp back into the signed WAVE_W+1 range.
  logic [WAVE_W:0]   shaped;
  logic [WAVE_W+1:0] osum;

  always_comb begin
    shaped = a_inv ? -{1'b0, val_q} : {1'b0, val_q};
    osum   = {shaped[WAVE_W], shaped}
             + {a_off[WAVE_W], a_off};
    out_d  = osum[WAVE_W:0];
    if (osum[WAVE_W+1] != osum[WAVE_W])
      out_d = osum[WAVE_W+1] ? {1'b1, {WAVE_W{1'b0}}}
                             : {1'b0, {WAVE_W{1'b1}}};
  end

  always_comb begin
    out_o          = out_q;
    state_o        = state_q;
    busy_o         = !idle;
    period_start_o = start;
    cfg_ready_o    = !s_full;
  end

endmodule

// File: tb/tb_fg_trapezoid_gen.sv
// tb_fg_trapezoid_gen: directed table-driven bench for
// fg_trapezoid_gen (WAVE_W=16, CNT_W=32).
module tb_fg_trapezoid_gen;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        enable;
  logic        mode;
  logic        trig;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] period;
  logic [31:0] on_time;
  logic [15:0] k_rise;
  logic [15:0] k_fall;
  logic [15:0] amp;
  logic [16:0] offset;
  logic        invert;
  logic [16:0] out;
  logic [2:0]  state;
  logic        busy;
  logic        ps;

  int checks = 0;
  int failures = 0;

  fg_trapezoid_gen #(
    .CNT_W  (32),
    .WAVE_W (16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clk_en_i       (clk_en),
    .enable_i       (enable),
    .mode_i         (mode),
    .trig_i         (trig),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .period_i       (period),
    .on_time_i      (on_time),
    .k_rise_i       (k_rise),
    .k_fall_i       (k_fall),
    .amplitude_i    (amp),
    .offset_i       (offset),
    .invert_i       (invert),
    .out_o          (out),
    .state_o        (state),
    .busy_o         (busy),
    .period_start_o (ps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         en;
    bit         ps;
    logic [2:0] st;
    int         out;
  } vec_t;

  typedef struct {
    int off;
    bit inv;
    int exp0;
    int exp3;
  } sat_t;

  vec_t vec[21];
  sat_t sv[4];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_en = 1'b0;
    enable = 1'b0;
    mode = 1'b0;
    trig = 1'b0;
    cfg_valid = 1'b0;
    tick_clk();
    tick_clk();
    rst = 1'b0;
  endtask

  task automatic load_cfg(input int p, input int on,
                          input int kr, input int kf,
                          input int am, input int off,
                          input bit inv);
    period = 32'(p);
    on_time = 32'(on);
    k_rise = 16'(kr);
    k_fall = 16'(kf);
    amp = 16'(am);
    offset = 17'(off);
    invert = inv;
    enable = 1'b0;
    clk_en = 1'b1;
    cfg_valid = 1'b1;
    tick_clk();
    cfg_valid = 1'b0;
    tick_clk();
  endtask

  task automatic check_row(input int i, input string tag);
    enable = vec[i].en;
    #1;
    chk($sformatf("%s_ps%0d", tag, i), ps, vec[i].ps);
    tick_clk();
    chk($sformatf("%s_st%0d", tag, i), state, vec[i].st);
    chk($sformatf("%s_out%0d", tag, i), $signed(out), vec[i].out);
  endtask

  initial begin
    vec = '{
      '{1'b1, 1'b1, 3'd1, 0},
      '{1'b1, 1'b0, 3'd1, 0},
      '{1'b1, 1'b0, 3'd1, 100},
      '{1'b1, 1'b0, 3'd2, 200},
      '{1'b1, 1'b0, 3'd2, 250},
      '{1'b1, 1'b0, 3'd2, 250},
      '{1'b1, 1'b0, 3'd3, 250},
      '{1'b1, 1'b0, 3'd3, 250},
      '{1'b1, 1'b0, 3'd3, 200},
      '{1'b1, 1'b0, 3'd3, 150},
      '{1'b1, 1'b1, 3'd1, 100},
      '{1'b1, 1'b0, 3'd1, 0},
      '{1'b1, 1'b0, 3'd1, 100},
      '{1'b1, 1'b0, 3'd2, 200},
      '{1'b1, 1'b0, 3'd2, 250},
      '{1'b1, 1'b0, 3'd2, 250},
      '{1'b1, 1'b0, 3'd3, 250},
      '{1'b1, 1'b0, 3'd3, 250},
      '{1'b1, 1'b0, 3'd3, 200},
      '{1'b1, 1'b0, 3'd3, 150},
      '{1'b1, 1'b1, 3'd1, 100}
    };
    sv = '{
      '{2,  1'b0, 2,  65535},
      '{-5, 1'b1, -5, -65536},
      '{-5, 1'b0, -5, 65530},
      '{0,  1'b1, 0,  -65535}
    };
    period = '0;
    on_time = '0;
    k_rise = '0;
    k_fall = '0;
    amp = '0;
    offset = '0;
    invert = 1'b0;

    // Reset state
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_out", $signed(out), 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ps", ps, 0);

    // Continuous, two full periods
    load_cfg(10, 6, 100, 50, 250, 0, 1'b0);
    mode = 1'b0;
    for (int i = 0; i < 21; i++) check_row(i, "cont");
    chk("cont_busy", busy, 1);

    // Early fall before amplitude is reached
    begin
      int est[5];
      int eout[5];
      est = '{1, 3, 3, 4, 4};
      eout = '{0, 100, 200, 100, 0};
      do_reset();
      load_cfg(10, 2, 100, 100, 1000, 0, 1'b0);
      enable = 1'b1;
      tick_clk();
      for (int i = 0; i < 5; i++) begin
        tick_clk();
        chk($sformatf("early_st%0d", i + 1), state, est[i]);
        chk($sformatf("early_out%0d", i + 1), $signed(out), eout[i]);
      end
    end

    // One-shot
    do_reset();
    load_cfg(5, 3, 10, 10, 20, 0, 1'b0);
    mode = 1'b1;
    enable = 1'b1;
    tick_clk();
    tick_clk();
    chk("os_wait_st", state, 0);
    trig = 1'b1;
    #1;
    chk("os_start_ps", ps, 1);
    tick_clk();
    trig = 1'b0;
    chk("os_run_st", state, 1);
    tick_clk();
    tick_clk();
    trig = 1'b1;
    #1;
    chk("os_midtrig_ps", ps, 0);
    tick_clk();
    chk("os_fall_st", state, 3);
    tick_clk();
    trig = 1'b0;
    chk("os_busy4", busy, 1);
    tick_clk();
    chk("os_end_st", state, 0);
    chk("os_end_busy", busy, 0);
    tick_clk();
    tick_clk();
    chk("os_stay_idle", state, 0);

    // Config change mid-period
    do_reset();
    load_cfg(10, 6, 100, 50, 250, 0, 1'b0);
    mode = 1'b0;
    enable = 1'b1;
    tick_clk();
    repeat (4) tick_clk();
    amp = 16'd500;
    cfg_valid = 1'b1;
    #1;
    chk("mid_ready_pre", cfg_ready, 1);
    tick_clk();
    cfg_valid = 1'b0;
    chk("mid_ready_cap", cfg_ready, 0);
    chk("mid_out5", $signed(out), 250);
    tick_clk();
    amp = 16'd777;
    cfg_valid = 1'b1;
    tick_clk();
    cfg_valid = 1'b0;
    chk("mid_ready_2nd", cfg_ready, 0);
    tick_clk();
    tick_clk();
    chk("mid_ready9", cfg_ready, 0);
    chk("mid_out9", $signed(out), 150);
    #1;
    chk("mid_ps10", ps, 1);
    tick_clk();
    chk("mid_ready10", cfg_ready, 1);
    chk("mid_out10", $signed(out), 100);
    repeat (5) tick_clk();
    chk("mid_out15", $signed(out), 400);
    tick_clk();
    chk("mid_out16", $signed(out), 500);
    chk("mid_st16", state, 3);
    tick_clk();
    chk("mid_out17", $signed(out), 500);

    // Saturation and inversion at full-scale plateau
    for (int c = 0; c < 4; c++) begin
      do_reset();
      load_cfg(20, 20, 65535, 0, 65535, sv[c].off, sv[c].inv);
      enable = 1'b1;
      tick_clk();
      chk($sformatf("sat%0d_out0", c), $signed(out), sv[c].exp0);
      tick_clk();
      tick_clk();
      chk($sformatf("sat%0d_st2", c), state, 2);
      tick_clk();
      chk($sformatf("sat%0d_out3", c), $signed(out), sv[c].exp3);
    end

    // Gated ticks 1-in-3, then reset mid-period
    do_reset();
    load_cfg(10, 6, 100, 50, 250, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      clk_en = 1'b1;
      check_row(i, "gate");
      clk_en = 1'b0;
      for (int g = 0; g < 2; g++) begin
        if (i == 2 && g == 0) begin
          amp = 16'd999;
          cfg_valid = 1'b1;
        end
        #1;
        chk($sformatf("gate_ps%0d_%0d", i, g), ps, 0);
        tick_clk();
        cfg_valid = 1'b0;
        chk($sformatf("gate_hold_st%0d_%0d", i, g), state, vec[i].st);
        chk($sformatf("gate_hold_out%0d_%0d", i, g),
            $signed(out), vec[i].out);
        if (i == 2 && g == 0)
          chk("gate_cfg_cap", cfg_ready, 0);
      end
    end
    rst = 1'b1;
    tick_clk();
    rst = 1'b0;
    chk("grst_state", state, 0);
    chk("grst_out", $signed(out), 0);
    chk("grst_ready", cfg_ready, 1);
    chk("grst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
